// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream and register-bank signals shared by the SPI command decoder and its neighbours.
interface spi_cmd_decoder_if;
  logic [7:0] rec_data;
  logic       rec_valid;
  logic [7:0] response_data;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       frame_done;
  logic       frame_err;

  modport slave (
    input  rec_data, rec_valid, reg_rdata,
    output response_data, reg_addr, reg_wdata, reg_wr, reg_rd, frame_done, frame_err
  );

  modport master (
    output rec_data, rec_valid, reg_rdata,
    input  response_data, reg_addr, reg_wdata, reg_wr, reg_rd, frame_done, frame_err
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Parses chip-select frames of {rw, addr} + data bytes into register-bank strobes
// with auto-incrementing address; read data returns in the next SPI byte slot.
module spi_cmd_decoder #(
  parameter logic [7:0]  STATUS_BYTE = 8'hA5,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  spi_cmd_decoder_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CMD, WR_DATA, RD_WAIT, RD_DATA} state_t;

  state_t     state, state_nxt;
  logic       cs_q1, cs_q2, cs_q3;
  logic [1:0] sync_vld;
  logic       armed;
  logic       cs_fall, cs_rise;

  logic [2:0] byte_cnt, cnt_nxt;
  logic [1:0] lat_cnt, lat_nxt;
  logic       err_hold, err_nxt;
  logic       inc_pend, inc_nxt;
  logic [6:0] addr_q, addr_nxt;
  logic [7:0] wdata_q, wdata_nxt;
  logic [7:0] resp_q, resp_nxt;
  logic       wr_q, wr_nxt, rd_q, rd_nxt;
  logic       done_q, done_nxt, ferr_q, ferr_nxt;

  // A frame may only start once cs_n has been genuinely sampled high after reset;
  // sync_vld marks when cs_q2 holds a real sample rather than its reset value.
  assign cs_fall = armed & cs_q3 & ~cs_q2;
  assign cs_rise = cs_q2 & ~cs_q3;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = byte_cnt;
    lat_nxt   = lat_cnt;
    err_nxt   = err_hold;
    inc_nxt   = 1'b0;
    addr_nxt  = inc_pend ? addr_q + 7'd1 : addr_q;
    wdata_nxt = wdata_q;
    resp_nxt  = resp_q;
    wr_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;

    if (state != IDLE && bus.rec_valid && byte_cnt != 3'd7)
      cnt_nxt = byte_cnt + 3'd1;

    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = CMD;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          resp_nxt  = STATUS_BYTE;
        end
      end
      CMD: begin
        if (bus.rec_valid) begin
          addr_nxt = bus.rec_data[6:0];
          if (bus.rec_data[7]) begin
            rd_nxt    = 1'b1;
            lat_nxt   = '0;
            state_nxt = RD_WAIT;
          end else begin
            state_nxt = WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (bus.rec_valid) begin
          wdata_nxt = bus.rec_data;
          resp_nxt  = bus.rec_data;
          wr_nxt    = 1'b1;
          inc_nxt   = 1'b1;
        end
      end
      RD_WAIT: begin
        if (bus.rec_valid)
          err_nxt = 1'b1;
        if (lat_cnt == 2'(RD_LAT)) begin
          resp_nxt  = bus.reg_rdata;
          state_nxt = RD_DATA;
        end else begin
          lat_nxt = lat_cnt + 2'd1;
        end
      end
      RD_DATA: begin
        if (bus.rec_valid) begin
          addr_nxt  = addr_q + 7'd1;
          rd_nxt    = 1'b1;
          lat_nxt   = '0;
          state_nxt = RD_WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Frame end overrides the byte just handled: writes and counting stand,
    // but a read launched by that byte and any pending capture are dropped.
    if (state != IDLE && cs_rise) begin
      state_nxt = IDLE;
      done_nxt  = 1'b1;
      ferr_nxt  = (cnt_nxt < 3'd2) | err_nxt;
      resp_nxt  = STATUS_BYTE;
      rd_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q1    <= 1'b1;
      cs_q2    <= 1'b1;
      cs_q3    <= 1'b1;
      sync_vld <= '0;
      armed    <= 1'b0;
      state    <= IDLE;
      byte_cnt <= '0;
      lat_cnt  <= '0;
      err_hold <= 1'b0;
      inc_pend <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= STATUS_BYTE;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      cs_q1    <= cs_n;
      cs_q2    <= cs_q1;
      cs_q3    <= cs_q2;
      sync_vld <= {sync_vld[0], 1'b1};
      armed    <= armed | (sync_vld[1] & cs_q2);
      state    <= state_nxt;
      byte_cnt <= cnt_nxt;
      lat_cnt  <= lat_nxt;
      err_hold <= err_nxt;
      inc_pend <= inc_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      resp_q   <= resp_nxt;
      wr_q     <= wr_nxt;
      rd_q     <= rd_nxt;
      done_q   <= done_nxt;
      ferr_q   <= ferr_nxt;
    end
  end

  assign bus.response_data = resp_q;
  assign bus.reg_addr      = addr_q;
  assign bus.reg_wdata     = wdata_q;
  assign bus.reg_wr        = wr_q;
  assign bus.reg_rd        = rd_q;
  assign bus.frame_done    = done_q;
  assign bus.frame_err     = ferr_q;

endmodule
